// File: rtl/power_seq_if.sv
// ----------------------------------------------------------------------------
// power_seq_if
//   Signal bundle between the rail sequencer and its environment (board power
//   state machine, rail regulators, SoC reset and the CPLD register file).
//
//   Signals (NUM_RAILS = number of sequenced rails, 2..8):
//     ce_tick     1          single-cycle timebase strobe for all delays
//     pwr_enable  1          level-sensitive power request
//     pg          NUM_RAILS  per-rail power-good, synchronised, active-high
//     rail_en     NUM_RAILS  per-rail enable
//     soc_reset   1          SoC reset, active-high
//     pwr_ok      1          high only while all rails are up and reset released
//     fault       1          sticky sequencing fault
//     fault_rail  3          index of the rail that caused the fault
//
//   Modports:
//     master  environment side: drives the request/timebase/power-good inputs
//     slave   sequencer side:   drives the enables, reset and status outputs
// ----------------------------------------------------------------------------
interface power_seq_if #(
    parameter int NUM_RAILS = 4
);
    logic                 ce_tick;
    logic                 pwr_enable;
    logic [NUM_RAILS-1:0] pg;
    logic [NUM_RAILS-1:0] rail_en;
    logic                 soc_reset;
    logic                 pwr_ok;
    logic                 fault;
    logic [2:0]           fault_rail;

    modport master (
        output ce_tick, pwr_enable, pg,
        input  rail_en, soc_reset, pwr_ok, fault, fault_rail
    );

    modport slave (
        input  ce_tick, pwr_enable, pg,
        output rail_en, soc_reset, pwr_ok, fault, fault_rail
    );
endinterface

// File: rtl/power_seq.sv
// ----------------------------------------------------------------------------
// power_seq
//   Rail sequencer downstream of the board power state machine. Turns the
//   single pwr_enable request into an ordered per-rail enable sequence
//   (rail 0 first), waits for each rail's power-good with a timeout, holds the
//   SoC in reset until every rail is good, and shuts down in reverse order.
//   A missing power-good drops all rails at once and latches a sticky fault
//   with the failing rail index.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset (drops every rail immediately)
//     bus   power_seq_if.slave: ce_tick, pwr_enable, pg in;
//           rail_en, soc_reset, pwr_ok, fault, fault_rail out (all registered)
//
//   Parameters (delays counted in ce_tick periods, 4-bit saturating counter):
//     NUM_RAILS   number of sequenced rails, 2..8
//     PG_TIMEOUT  ticks allowed for pg[i] after rail_en[i] rises
//     STEP_DELAY  ticks between pg[i] and rail_en[i+1]; also rail-off dwell
//     RST_DELAY   ticks after the last pg before soc_reset deasserts
//
//   Build option:
//     POWER_SEQ_PG_MONITOR_EN  when defined, loss of pg on any enabled rail in
//                              RST_HOLD or ON is a fault (lowest failing index
//                              reported). When undefined, pg is only looked at
//                              while waiting for a rail to come up.
// ----------------------------------------------------------------------------
module power_seq #(
    parameter int         NUM_RAILS  = 4,
    parameter logic [3:0] PG_TIMEOUT = 4'd4,
    parameter logic [3:0] STEP_DELAY = 4'd1,
    parameter logic [3:0] RST_DELAY  = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    power_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_OFF,
        S_UP_WAIT,
        S_UP_STEP,
        S_RST_HOLD,
        S_ON,
        S_DOWN,
        S_FAULT
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_RAILS - 1);

    state_t               state_q;
    logic [2:0]           idx_q;
    logic [3:0]           cnt_q;
    logic [NUM_RAILS-1:0] rail_en_q;
    logic                 soc_reset_q;
    logic                 pwr_ok_q;
    logic                 fault_q;
    logic [2:0]           fault_rail_q;

    logic [3:0] cnt_d;        // tick counter after this cycle's (possible) tick
    logic       pg_sel;       // pg of the rail currently being sequenced
    logic       pg_timeout;
    logic       step_done;
    logic       rst_done;
    logic       mon_fail;
    logic [2:0] mon_rail;
    logic       enter_fault;
    logic [2:0] fault_idx;
    logic       start_down;

    // One-hot mask for rail i; indices beyond NUM_RAILS select nothing, which
    // keeps the 3-bit index legal for any rail count.
    function automatic logic [NUM_RAILS-1:0] rail_bit(input logic [2:0] i);
        rail_bit = '0;
        for (int r = 0; r < NUM_RAILS; r++) begin
            if (i == 3'(r)) rail_bit[r] = 1'b1;
        end
    endfunction

    // Counter only moves on ce_tick and sticks at all-ones instead of wrapping.
    assign cnt_d = (bus.ce_tick && (cnt_q != 4'hF)) ? cnt_q + 4'd1 : cnt_q;

    // Comparing the post-tick count lets a zero delay complete on the very
    // next clock without waiting for a tick, and >= covers saturation.
    assign pg_timeout = (cnt_d >= PG_TIMEOUT);
    assign step_done  = (cnt_d >= STEP_DELAY);
    assign rst_done   = (cnt_d >= RST_DELAY);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        pg_sel = 1'b0;
        for (int r = 0; r < NUM_RAILS; r++) begin
            if (idx_q == 3'(r)) pg_sel = bus.pg[r];
        end
    end

`ifdef POWER_SEQ_PG_MONITOR_EN
    // Scan downwards so the lowest failing rail is the one left in mon_rail.
    always_comb begin
        mon_fail = 1'b0;
        mon_rail = '0;
        for (int r = NUM_RAILS - 1; r >= 0; r--) begin
            if (rail_en_q[r] && !bus.pg[r]) begin
                mon_fail = 1'b1;
                mon_rail = 3'(r);
            end
        end
    end
`else
    assign mon_fail = 1'b0;
    assign mon_rail = '0;
`endif

    // Fault detection takes priority over everything else in the same cycle,
    // including a simultaneous drop of pwr_enable. A pg arriving on the final
    // timeout tick is a pass because pg is checked before the timeout.
    always_comb begin
        enter_fault = 1'b0;
        fault_idx   = idx_q;
        start_down  = 1'b0;
        case (state_q)
            S_UP_WAIT: begin
                enter_fault = !pg_sel && pg_timeout;
                start_down  = !bus.pwr_enable;
            end
            S_UP_STEP: start_down = !bus.pwr_enable;
            S_RST_HOLD, S_ON: begin
                enter_fault = mon_fail;
                fault_idx   = mon_rail;
                start_down  = !bus.pwr_enable;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register in
    // this block updates from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            rail_en_q    <= '0;
            soc_reset_q  <= 1'b1;
            pwr_ok_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
        end else if (enter_fault) begin
            // Emergency off: all rails at once, not sequenced.
            state_q      <= S_FAULT;
            cnt_q        <= '0;
            rail_en_q    <= '0;
            soc_reset_q  <= 1'b1;
            pwr_ok_q     <= 1'b0;
            fault_q      <= 1'b1;
            fault_rail_q <= fault_idx;
        end else if (start_down) begin
            // Normal shutdown from ON or an abort mid-ramp: unwind from the
            // current rail, clearing it on this edge. In RST_HOLD and ON the
            // index already points at the last rail.
            state_q     <= S_DOWN;
            cnt_q       <= '0;
            rail_en_q   <= rail_en_q & ~rail_bit(idx_q);
            soc_reset_q <= 1'b1;
            pwr_ok_q    <= 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    rail_en_q   <= '0;
                    soc_reset_q <= 1'b1;
                    pwr_ok_q    <= 1'b0;
                    if (bus.pwr_enable) begin
                        fault_q      <= 1'b0;
                        fault_rail_q <= '0;
                        idx_q        <= '0;
                        cnt_q        <= '0;
                        rail_en_q    <= rail_bit(3'd0);
                        state_q      <= S_UP_WAIT;
                    end
                end
                S_UP_WAIT: begin
                    if (pg_sel) begin
                        cnt_q   <= '0;
                        state_q <= (idx_q == LAST_IDX) ? S_RST_HOLD : S_UP_STEP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_UP_STEP: begin
                    if (step_done) begin
                        idx_q     <= idx_q + 3'd1;
                        rail_en_q <= rail_en_q | rail_bit(idx_q + 3'd1);
                        cnt_q     <= '0;
                        state_q   <= S_UP_WAIT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RST_HOLD: begin
                    if (rst_done) begin
                        soc_reset_q <= 1'b0;
                        pwr_ok_q    <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_ON;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_ON: ;
                S_DOWN: begin
                    // pg and pwr_enable are ignored until OFF is reached.
                    if (step_done) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd0) begin
                            state_q <= S_OFF;
                        end else begin
                            idx_q     <= idx_q - 3'd1;
                            rail_en_q <= rail_en_q & ~rail_bit(idx_q - 3'd1);
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_FAULT: begin
                    // Fault stays latched through OFF until the next power-up.
                    if (!bus.pwr_enable) state_q <= S_OFF;
                end
                default: state_q <= S_OFF;
            endcase
        end
    end

    assign bus.rail_en    = rail_en_q;
    assign bus.soc_reset  = soc_reset_q;
    assign bus.pwr_ok     = pwr_ok_q;
    assign bus.fault      = fault_q;
    assign bus.fault_rail = fault_rail_q;

endmodule

// File: tb/tb_power_seq.sv
// ----------------------------------------------------------------------------
// tb_power_seq
//   Directed bench for power_seq with NUM_RAILS=4, PG_TIMEOUT=4, STEP_DELAY=1,
//   RST_DELAY=2. Each step drives the inputs, pushes the expected output
//   snapshot {rail_en, soc_reset, pwr_ok, fault, fault_rail} onto a
//   scoreboard queue, advances one clock and pops/compares after the edge.
//   Expectations for the pg-loss step follow POWER_SEQ_PG_MONITOR_EN.
// ----------------------------------------------------------------------------
module tb_power_seq;

    logic clk;
    logic rst;

    power_seq_if #(.NUM_RAILS(4)) bus ();

    power_seq #(
        .NUM_RAILS (4),
        .PG_TIMEOUT(4'd4),
        .STEP_DELAY(4'd1),
        .RST_DELAY (4'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef POWER_SEQ_PG_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    function automatic logic [3:0] mask(input int n);
        return 4'((1 << n) - 1);
    endfunction

    task automatic expect_out(input string tag, input logic [3:0] re, input logic sr,
                              input logic ok, input logic f, input logic [2:0] fr);
        exp_t e;
        e.tag = tag;
        e.exp = {re, sr, ok, f, fr};
        sb_q.push_back(e);
    endtask

    task automatic check();
        exp_t       e;
        logic [9:0] obs;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed no expectation, required one queued");
            return;
        end
        e   = sb_q.pop_front();
        obs = {bus.rail_en, bus.soc_reset, bus.pwr_ok, bus.fault, bus.fault_rail};
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed rail_en=%b soc_reset=%b pwr_ok=%b fault=%b fault_rail=%0d, expected rail_en=%b soc_reset=%b pwr_ok=%b fault=%b fault_rail=%0d",
                   e.tag, obs[9:6], obs[5], obs[4], obs[3], obs[2:0],
                   e.exp[9:6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
        end
    endtask

    // One clock with ce_tick = t; inputs change 1 time unit after the edge.
    task automatic cyc(input bit t);
        bus.ce_tick = t;
        @(posedge clk);
        #1;
        bus.ce_tick = 1'b0;
    endtask

    task automatic step(input bit t, input string tag, input logic [3:0] re, input logic sr,
                        input logic ok, input logic f, input logic [2:0] fr);
        expect_out(tag, re, sr, ok, f, fr);
        cyc(t);
        check();
    endtask

    initial begin
        rst            = 1'b1;
        bus.ce_tick    = 1'b0;
        bus.pwr_enable = 1'b0;
        bus.pg         = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and idle OFF.
        expect_out("reset_values", 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
        check();
        step(1'b1, "off_idle", 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);

        // 1. Normal power-up.
        bus.pwr_enable = 1'b1;
        step(1'b0, "up_en0", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (2) step(1'b0, "up_wait_pg", mask(i + 1), 1'b1, 1'b0, 1'b0, 3'd0);
            bus.pg[i] = 1'b1;
            step(1'b0, "up_pg_seen", mask(i + 1), 1'b1, 1'b0, 1'b0, 3'd0);
            if (i < 3) begin
                step(1'b0, "up_step_no_tick", mask(i + 1), 1'b1, 1'b0, 1'b0, 3'd0);
                step(1'b1, "up_step_next", mask(i + 2), 1'b1, 1'b0, 1'b0, 3'd0);
            end else begin
                step(1'b1, "rst_hold_tick1", 4'b1111, 1'b1, 1'b0, 1'b0, 3'd0);
                step(1'b1, "power_on", 4'b1111, 1'b0, 1'b1, 1'b0, 3'd0);
            end
        end
        step(1'b1, "on_stable", 4'b1111, 1'b0, 1'b1, 1'b0, 3'd0);

        // 2. Orderly shutdown; re-enable during DOWN is ignored until OFF.
        bus.pwr_enable = 1'b0;
        step(1'b0, "dn_start", 4'b0111, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, "dn_dwell", 4'b0111, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "dn_rail2", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "dn_rail1", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "dn_rail0", 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pg         = 4'b0000;
        bus.pwr_enable = 1'b1;
        step(1'b0, "dn_ignore_enable", 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "dn_to_off", 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, "off_restart", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);

        // 3. Timeout on rail 2.
        bus.pg[0] = 1'b1;
        step(1'b0, "t3_pg0", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t3_en1", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pg[1] = 1'b1;
        step(1'b0, "t3_pg1", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t3_en2", 4'b0111, 1'b1, 1'b0, 1'b0, 3'd0);
        repeat (3) step(1'b1, "t3_before_timeout", 4'b0111, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t3_timeout", 4'b0000, 1'b1, 1'b0, 1'b1, 3'd2);
        step(1'b1, "t3_fault_hold", 4'b0000, 1'b1, 1'b0, 1'b1, 3'd2);
        bus.pwr_enable = 1'b0;
        step(1'b0, "t3_off_sticky", 4'b0000, 1'b1, 1'b0, 1'b1, 3'd2);
        step(1'b1, "t3_off_idle", 4'b0000, 1'b1, 1'b0, 1'b1, 3'd2);
        bus.pwr_enable = 1'b1;
        step(1'b0, "t3_fault_clear", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);

        // 4. Abort in UP_STEP after rail 1 (pg[1:0] still high).
        step(1'b0, "t4_pg0", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t4_en1", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, "t4_pg1", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pwr_enable = 1'b0;
        step(1'b0, "t4_abort_rail1", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t4_rail0", 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t4_off", 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pg = 4'b0000;

        // 5. pg on the PG_TIMEOUT-th tick passes; then pg loss while ON.
        bus.pwr_enable = 1'b1;
        step(1'b0, "t5_en0", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        repeat (3) step(1'b1, "t5_wait", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pg[0] = 1'b1;
        step(1'b1, "t5_pg_on_last_tick", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t5_en1", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 1; i < 4; i++) begin
            bus.pg[i] = 1'b1;
            step(1'b0, "t5_pg_seen", mask(i + 1), 1'b1, 1'b0, 1'b0, 3'd0);
            if (i < 3) begin
                step(1'b1, "t5_step_next", mask(i + 2), 1'b1, 1'b0, 1'b0, 3'd0);
            end else begin
                step(1'b1, "t5_rst_hold", 4'b1111, 1'b1, 1'b0, 1'b0, 3'd0);
                step(1'b1, "t5_on", 4'b1111, 1'b0, 1'b1, 1'b0, 3'd0);
            end
        end
        bus.pg = 4'b1101;
        if (MON) step(1'b0, "t5_pg1_drop", 4'b0000, 1'b1, 1'b0, 1'b1, 3'd1);
        else     step(1'b0, "t5_pg1_drop", 4'b1111, 1'b0, 1'b1, 1'b0, 3'd0);
        bus.pg = 4'b1111;
        if (MON) step(1'b0, "t5_after_drop", 4'b0000, 1'b1, 1'b0, 1'b1, 3'd1);
        else     step(1'b0, "t5_after_drop", 4'b1111, 1'b0, 1'b1, 1'b0, 3'd0);

        bus.pwr_enable = 1'b0;
        bus.pg         = 4'b0000;
        repeat (6) cyc(1'b1);
        expect_out("t5_settled_off", 4'b0000, 1'b1, 1'b0, MON, MON ? 3'd1 : 3'd0);
        check();

        // 6. Async reset while waiting for rail 2.
        bus.pwr_enable = 1'b1;
        step(1'b0, "t6_en0", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pg = 4'b0001;
        step(1'b0, "t6_pg0", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t6_en1", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
        bus.pg = 4'b0011;
        step(1'b0, "t6_pg1", 4'b0011, 1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, "t6_en2", 4'b0111, 1'b1, 1'b0, 1'b0, 3'd0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("t6_async_reset", 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
        check();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        bus.pg = 4'b0000;
        step(1'b0, "t6_restart_from_off", 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
